// File: rtl/axgpio_pkg.sv
// axgpio_pkg: GPIO register map offsets, channel response codes and address decode helpers
package axgpio_pkg;
    localparam logic [7:0] ADR_DOUT = 8'h00;
    localparam logic [7:0] ADR_DIR  = 8'h04;
    localparam logic [7:0] ADR_DIN  = 8'h08;
    localparam logic [7:0] ADR_IEN  = 8'h0C;
    localparam logic [7:0] ADR_STAT = 8'h10;
    localparam logic [7:0] ADR_EDGE = 8'h14;

    typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_e;

    // Listed offsets are all aligned, so unaligned addresses fall out as errors too
    function automatic resp_e rd_resp(input logic [7:0] adr);
        return (adr inside {ADR_DOUT, ADR_DIR, ADR_DIN, ADR_IEN, ADR_STAT, ADR_EDGE}) ? OKAY : SLVERR;
    endfunction

    function automatic resp_e wr_resp(input logic [7:0] adr);
        return (adr inside {ADR_DOUT, ADR_DIR, ADR_IEN, ADR_STAT, ADR_EDGE}) ? OKAY : SLVERR;
    endfunction
endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: pad input synchroniser with edge detection, masked during post-reset warm-up
module gpio_sync_edge #(
    parameter int GPIO_W   = 32,
    parameter int SYNC_LEN = 2
) (
    input  logic              iCLK,
    input  logic              iRSTN,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] sync_o,
    output logic [GPIO_W-1:0] rise_o,
    output logic [GPIO_W-1:0] fall_o
);
    localparam int CW = $clog2(SYNC_LEN + 2);
    localparam logic [CW-1:0] ARM = CW'(SYNC_LEN + 1);

    logic [GPIO_W-1:0] sync_q [SYNC_LEN];
    logic [GPIO_W-1:0] prev_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              armed;

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            for (int i = 0; i < SYNC_LEN; i++) sync_q[i] <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_LEN; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_o;
            cnt_q  <= cnt_d;
        end
    end

    // Until the chain and prev flop hold real pin values, the reset-to-pin step is not an edge
    always_comb begin
        armed  = cnt_q == ARM;
        cnt_d  = armed ? cnt_q : cnt_q + 1'b1;
        sync_o = sync_q[SYNC_LEN-1];
        rise_o = armed ? (sync_o & ~prev_q) : '0;
        fall_o = armed ? (~sync_o & prev_q) : '0;
    end
endmodule

// File: rtl/axgpio_regfile.sv
// axgpio_regfile: GPIO control/status registers behind the AXI4-Lite write/read strobes
module axgpio_regfile import axgpio_pkg::*; #(
    parameter int GPIO_W   = 32,
    parameter int SYNC_LEN = 2
) (
    input  logic              iCLK,
    input  logic              iRSTN,
    input  logic [7:0]        iPWADR,
    input  logic [31:0]       iPWDAT,
    input  logic              iPWRTE,
    output logic              oPWERR,
    input  logic [7:0]        iPRADR,
    input  logic              iPREAD,
    output logic [31:0]       oPRDAT,
    output logic              oPRERR,
    input  logic [GPIO_W-1:0] iGPIO_I,
    output logic [GPIO_W-1:0] oGPIO_O,
    output logic [GPIO_W-1:0] oGPIO_OE,
    output logic              oIRQ
);
    logic [GPIO_W-1:0] dout_q, dout_d, dir_q, dir_d, ien_q, ien_d;
    logic [GPIO_W-1:0] stat_q, stat_d, edge_q, edge_d;
    logic [GPIO_W-1:0] sync, rise, fall, evt, wdat, rsel;
    logic [31:0]       rdat_q, rdat_d;
    logic              pwerr_q, pwerr_d, prerr_q, prerr_d, irq_q, irq_d, wok, rok;

    gpio_sync_edge #(.GPIO_W(GPIO_W), .SYNC_LEN(SYNC_LEN)) u_sync (
        .iCLK   (iCLK),
        .iRSTN  (iRSTN),
        .gpio_i (iGPIO_I),
        .sync_o (sync),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_comb begin
        wdat    = iPWDAT[GPIO_W-1:0];
        wok     = iPWRTE && wr_resp(iPWADR) == OKAY;
        pwerr_d = iPWRTE && wr_resp(iPWADR) == SLVERR;
        dout_d  = (wok && iPWADR == ADR_DOUT) ? wdat : dout_q;
        dir_d   = (wok && iPWADR == ADR_DIR)  ? wdat : dir_q;
        ien_d   = (wok && iPWADR == ADR_IEN)  ? wdat : ien_q;
        edge_d  = (wok && iPWADR == ADR_EDGE) ? wdat : edge_q;
        evt     = (edge_q & rise) | (~edge_q & fall);
        stat_d  = evt | (stat_q & ~((wok && iPWADR == ADR_STAT) ? wdat : '0));
        irq_d   = |(stat_q & ien_q);
        rok     = iPREAD && rd_resp(iPRADR) == OKAY;
        rsel    = iPRADR == ADR_DOUT ? dout_q :
                  iPRADR == ADR_DIR  ? dir_q  :
                  iPRADR == ADR_DIN  ? sync   :
                  iPRADR == ADR_IEN  ? ien_q  :
                  iPRADR == ADR_STAT ? stat_q : edge_q;
        rdat_d  = rok ? 32'(rsel) : '0;
        prerr_d = iPREAD && !rok;
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            dout_q  <= '0;
            dir_q   <= '0;
            ien_q   <= '0;
            stat_q  <= '0;
            edge_q  <= '0;
            rdat_q  <= '0;
            pwerr_q <= 1'b0;
            prerr_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            dir_q   <= dir_d;
            ien_q   <= ien_d;
            stat_q  <= stat_d;
            edge_q  <= edge_d;
            rdat_q  <= rdat_d;
            pwerr_q <= pwerr_d;
            prerr_q <= prerr_d;
            irq_q   <= irq_d;
        end
    end

    assign oGPIO_O  = dout_q;
    assign oGPIO_OE = dir_q;
    assign oPWERR   = pwerr_q;
    assign oPRDAT   = rdat_q;
    assign oPRERR   = prerr_q;
    assign oIRQ     = irq_q;
endmodule

// File: tb/tb_axgpio_regfile.sv
// tb_axgpio_regfile: directed stimulus with queued expectations checked by a cycle monitor
module tb_axgpio_regfile;
    import axgpio_pkg::*;

    logic        iCLK = 1'b0;
    logic        iRSTN = 1'b1;
    logic [7:0]  iPWADR = '0;
    logic [31:0] iPWDAT = '0;
    logic        iPWRTE = 1'b0;
    logic        oPWERR;
    logic [7:0]  iPRADR = '0;
    logic        iPREAD = 1'b0;
    logic [31:0] oPRDAT;
    logic        oPRERR;
    logic [31:0] iGPIO_I = 32'hFFFF_FFFF;
    logic [31:0] oGPIO_O, oGPIO_OE;
    logic        oIRQ;

    int total = 0;
    int bad = 0;
    logic        wq[$];
    logic [32:0] rq[$];
    logic        wf = 1'b0, rf = 1'b0;

    axgpio_regfile #(.GPIO_W(32), .SYNC_LEN(2)) dut (
        .iCLK     (iCLK),
        .iRSTN    (iRSTN),
        .iPWADR   (iPWADR),
        .iPWDAT   (iPWDAT),
        .iPWRTE   (iPWRTE),
        .oPWERR   (oPWERR),
        .iPRADR   (iPRADR),
        .iPREAD   (iPREAD),
        .oPRDAT   (oPRDAT),
        .oPRERR   (oPRERR),
        .iGPIO_I  (iGPIO_I),
        .oGPIO_O  (oGPIO_O),
        .oGPIO_OE (oGPIO_OE),
        .oIRQ     (oIRQ)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    task automatic wr(input logic [7:0] adr, input logic [31:0] dat, input logic err);
        iPWRTE = 1'b1;
        iPWADR = adr;
        iPWDAT = dat;
        wq.push_back(err);
    endtask

    task automatic rd(input logic [7:0] adr, input logic [31:0] dat, input logic err);
        iPREAD = 1'b1;
        iPRADR = adr;
        rq.push_back({err, dat});
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
        iPWRTE = 1'b0;
        iPREAD = 1'b0;
    endtask

    always @(posedge iCLK) begin
        wf = iPWRTE;
        rf = iPREAD;
    end

    always @(negedge iCLK) begin
        if (iRSTN) begin
            if (wf) begin
                if (wq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pwerr_unexpected_pop got=empty exp=entry");
                end else chk("pwerr", 32'(oPWERR), 32'(wq.pop_front()));
            end else chk("pwerr_idle", 32'(oPWERR), 32'd0);
            if (rf) begin
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected_pop got=empty exp=entry");
                end else begin
                    logic [32:0] e;
                    e = rq.pop_front();
                    chk("prdat", oPRDAT, e[31:0]);
                    chk("prerr", 32'(oPRERR), 32'(e[32]));
                end
            end else begin
                chk("prdat_idle", oPRDAT, 32'd0);
                chk("prerr_idle", 32'(oPRERR), 32'd0);
            end
        end
    end

    initial begin
        #1 iRSTN = 1'b0;
        @(posedge iCLK);
        #2;
        chk("rst_gpio_o", oGPIO_O, 32'd0);
        chk("rst_gpio_oe", oGPIO_OE, 32'd0);
        chk("rst_irq", 32'(oIRQ), 32'd0);
        chk("rst_pwerr", 32'(oPWERR), 32'd0);
        chk("rst_prdat", oPRDAT, 32'd0);
        chk("rst_prerr", 32'(oPRERR), 32'd0);
        step();
        iRSTN = 1'b1;
        // pins held high across reset release: warm-up must hide the apparent rise
        wr(ADR_EDGE, 32'hFFFF_FFFF, 1'b0);
        step();
        repeat (5) step();
        rd(ADR_STAT, 32'd0, 1'b0);
        step();
        wr(ADR_DIR, 32'h0000_00FF, 1'b0);
        step();
        chk("gpio_oe", oGPIO_OE, 32'h0000_00FF);
        wr(ADR_DOUT, 32'h0000_00A5, 1'b0);
        step();
        chk("gpio_o", oGPIO_O, 32'h0000_00A5);
        iGPIO_I = 32'd0;
        wr(ADR_IEN, 32'h8, 1'b0);
        step();
        repeat (4) step();
        rd(ADR_STAT, 32'd0, 1'b0);
        step();
        iGPIO_I = 32'h8;
        repeat (3) step();
        chk("irq_before", 32'(oIRQ), 32'd0);
        rd(ADR_STAT, 32'h8, 1'b0);
        step();
        chk("irq_set", 32'(oIRQ), 32'd1);
        wr(ADR_STAT, 32'h8, 1'b0);
        step();
        step();
        chk("irq_clr", 32'(oIRQ), 32'd0);
        rd(ADR_STAT, 32'd0, 1'b0);
        step();
        // bit 0 rise reaches STAT on the same edge as its W1C
        iGPIO_I = 32'h9;
        repeat (2) step();
        wr(ADR_STAT, 32'h1, 1'b0);
        step();
        rd(ADR_STAT, 32'h1, 1'b0);
        step();
        chk("irq_masked", 32'(oIRQ), 32'd0);
        wr(ADR_DIN, 32'hDEAD_BEEF, 1'b1);
        step();
        wr(8'h18, 32'h1234_5678, 1'b1);
        step();
        wr(8'h02, 32'hFFFF_FFFF, 1'b1);
        step();
        chk("dout_kept", oGPIO_O, 32'h0000_00A5);
        rd(ADR_DIN, 32'h9, 1'b0);
        step();
        rd(8'h20, 32'd0, 1'b1);
        step();
        rd(ADR_DIR, 32'h0000_00FF, 1'b0);
        step();
        rd(8'h01, 32'd0, 1'b1);
        step();
        wr(ADR_DOUT, 32'h0000_005A, 1'b0);
        rd(ADR_DOUT, 32'h0000_00A5, 1'b0);
        step();
        chk("gpio_o_new", oGPIO_O, 32'h0000_005A);
        rd(ADR_EDGE, 32'hFFFF_FFFF, 1'b0);
        step();
        repeat (2) step();
        chk("wq_left", wq.size(), 32'd0);
        chk("rq_left", rq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
